lcd_fb_arbiter: RTL and testbench
=================================

LCD_FB_ARBITER -- requirements
Module: lcd_fb_arbiter

Interface
REQ-001 The block SHALL have the port clk_8m  in  1  sole clock; all state on its rising edge.
REQ-002 The block SHALL have the port rst  in  1  asynchronous reset, active-high.
REQ-003 The block SHALL have the ports cur_xpos  in  8 and cur_ypos  in  8: panel position from the LCD timing controller, visible area 160x144.
REQ-004 The block SHALL have the port pix  out  2  2bpp shade for the current position.
REQ-005 The block SHALL have the ports host_req  in  1, host_we  in  1, host_addr  in  13, host_wdata  in  8: host access request, held until ack.
REQ-006 The block SHALL have the ports host_ack  out  1 (one-cycle pulse) and host_rdata  out  8 (valid with ack).
REQ-007 The block SHALL have the ports fb_addr  out  13, fb_wdata  out  8, fb_we  out  1, fb_rdata  in  8: single-port sync framebuffer RAM, read data valid 1 cycle after address.
REQ-008 The block SHALL have the port underrun  out  1: sticky scanout-miss flag.

Function
REQ-009 The framebuffer SHALL be 5760 bytes, 4 pixels/byte; group index G = ypos*40 + xpos[7:2]; pixel xpos[1:0]=0 in bits [7:6], 3 in [1:0].
REQ-010 The block SHALL register the position as pos_q; a move event occurs when {cur_ypos,cur_xpos} != pos_q; pos_q SHALL update on the next edge.
REQ-011 Positions with xpos>=160 or ypos>=144 SHALL be out-of-area: no fetch, no underrun, pix=0.
REQ-012 On an in-area move event with xpos[1:0]==0 (boundary), current byte SHALL load from the prefetch register if next_valid and next_tag==G; otherwise current SHALL load 0 and underrun SHALL set.
REQ-013 On each boundary the block SHALL invalidate prefetch and mark a scan fetch pending for G+1, with 5759 wrapping to 0.
REQ-014 pix SHALL be current byte field selected by pos_q[1:0], combinational from registers, i.e. 1 cycle after the position input changes.
REQ-015 FSM states SHALL be IDLE, SCAN_CAP, HOST_RD_CAP, HOST_WR; any state returns to IDLE after its single cycle.
REQ-016 In IDLE, a pending scan fetch SHALL win: fb_addr=tag, go SCAN_CAP; in SCAN_CAP, fb_rdata SHALL load into the prefetch register, next_valid=1, and pending SHALL clear.
REQ-017 In IDLE with no scan pending and host_req=1: for a write, fb_addr/fb_wdata drive with fb_we=1, go HOST_WR, host_ack=1 in HOST_WR; for a read, fb_addr drives, go HOST_RD_CAP, host_rdata=fb_rdata with host_ack=1.
REQ-018 host_addr>=5760 SHALL be acked on the following cycle with no RAM access (fb_we=0) and host_rdata=0.
REQ-019 A new boundary arriving while a fetch is pending SHALL overwrite the pending target; an in-flight SCAN_CAP SHALL complete with its old tag, then the tag compare decides.
REQ-020 The host SHALL be allowed to issue back-to-back: host_req sampled in IDLE on the cycle after ack starts a new access; the maximum host wait SHALL be 2 cycles of scan priority.
REQ-021 fb_we SHALL be high only in the issuing cycle of a valid write, and never during scan.

Reset
REQ-022 rst SHALL asynchronously clear: FSM=IDLE, pos_q=0, current=0, next_valid=0, underrun=0, host_ack=0, host_rdata=0, fb_we=0, fb_addr=0, and SHALL set scan pending with tag=0 so group 0 is prefetched.
REQ-023 rst asserted mid-access SHALL abort the access with no ack.

Configuration
REQ-024 With FB_HOST_READ_EN defined, host reads SHALL behave per REQ-017; without it, host_we=0 requests SHALL be acked the next cycle with host_rdata=0, no RAM access, and HOST_RD_CAP SHALL be absent.

Verification
REQ-025 The bench SHALL check: after reset, RAM[0]=0x1B, position (0,0)->(1,0)->...; then (0,0) re-presented via (159,143) -> pix sequence 0,1,2,3 at x=0..3, underrun=0.
REQ-026 The bench SHALL check: host write addr 40 data 0xE4, then scan row 1 -> pix at x=0..3 = 3,2,1,0.
REQ-027 The bench SHALL check: host_req held during a boundary -> SCAN_CAP precedes host access, host_ack within 3 cycles, single pulse.
REQ-028 The bench SHALL check: two boundaries 1 cycle apart (x=0 then x=4) -> underrun=1, pix=0, and underrun stays 1 until rst.
REQ-029 The bench SHALL check: host write addr 6000 -> ack next cycle, fb_we never high; host read addr 5 (RAM=0xA5) -> host_rdata=0xA5 with FB_HOST_READ_EN, 0x00 without.
REQ-030 The bench SHALL check: position (159,143) boundary at x=156 -> prefetch tag wraps to 0, and fb_addr=0 in the fetch cycle.

Source files
------------

// File: rtl/lcd_fb_arbiter.sv
// rtl/lcd_fb_arbiter.sv - LCD scanout / host framebuffer arbiter, 160x144 2bpp; optional host reads via FB_HOST_READ_EN
module lcd_fb_arbiter (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [7:0]  cur_xpos,
  input  logic [7:0]  cur_ypos,
  output logic [1:0]  pix,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        fb_we,
  input  logic [7:0]  fb_rdata,
  output logic        underrun
);

  localparam logic [12:0] FB_BYTES = 13'd5760;
  localparam logic [12:0] LAST_GRP = 13'd5759;

`ifdef FB_HOST_READ_EN
  localparam logic READ_EN = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN_CAP = 2'd1, HOST_RD_CAP = 2'd2, HOST_WR = 2'd3} state_t;
`else
  localparam logic READ_EN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN_CAP = 2'd1, HOST_WR = 2'd3} state_t;
`endif

  state_t      state;
  logic [15:0] pos_q;
  logic [7:0]  cur_byte;
  logic [7:0]  next_byte;
  logic [12:0] next_tag;
  logic        next_valid;
  logic        pend;
  logic [12:0] pend_tag;
  logic [12:0] cap_tag;

  logic        cur_in_area;
  logic        pos_in_area;
  logic        move;
  logic        boundary;
  logic [12:0] grp;
  logic [12:0] grp_next;
  logic        host_addr_ok;
  logic        host_ram;
  logic [1:0]  shade;

  assign cur_in_area  = (cur_xpos < 8'd160) && (cur_ypos < 8'd144);
  assign pos_in_area  = (pos_q[7:0] < 8'd160) && (pos_q[15:8] < 8'd144);
  assign move         = {cur_ypos, cur_xpos} != pos_q;
  assign boundary     = move && cur_in_area && (cur_xpos[1:0] == 2'b00);
  assign grp          = {5'd0, cur_ypos} * 13'd40 + {7'd0, cur_xpos[7:2]};
  assign grp_next     = (grp == LAST_GRP) ? 13'd0 : grp + 13'd1;
  assign host_addr_ok = host_addr < FB_BYTES;
  // Only in-range writes, and in-range reads when reads are built in, touch the RAM.
  assign host_ram     = host_req && host_addr_ok && (host_we || READ_EN);

  // Track the panel position; a change against pos_q is what defines a move event.
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      pos_q <= 16'd0;
    end else begin
      pos_q <= {cur_ypos, cur_xpos};
    end
  end

  // Arbiter FSM plus the scan pipeline (pending fetch, prefetch register, current byte).
  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_byte   <= 8'd0;
      next_byte  <= 8'd0;
      next_tag   <= 13'd0;
      next_valid <= 1'b0;
      pend       <= 1'b1;
      pend_tag   <= 13'd0;
      cap_tag    <= 13'd0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend) begin
            cap_tag <= pend_tag;
            state   <= SCAN_CAP;
          end else if (host_req) begin
`ifdef FB_HOST_READ_EN
            if (!host_we && host_addr_ok) state <= HOST_RD_CAP;
            else                          state <= HOST_WR;
`else
            // HOST_WR doubles as the ack cycle for requests that never reach the RAM.
            state <= HOST_WR;
`endif
          end
        end
        SCAN_CAP: begin
          next_byte  <= fb_rdata;
          next_tag   <= cap_tag;
          next_valid <= 1'b1;
          // A boundary that retargeted the fetch while it was in flight keeps it pending.
          if (pend_tag == cap_tag) pend <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Boundary handling comes last so it overrides the capture bookkeeping above.
      if (boundary) begin
        if (next_valid && (next_tag == grp)) begin
          cur_byte <= next_byte;
        end else begin
          cur_byte <= 8'd0;
          underrun <= 1'b1;
        end
        next_valid <= 1'b0;
        pend       <= 1'b1;
        pend_tag   <= grp_next;
      end
    end
  end

  // RAM port: scan fetch has priority; host access only issues from IDLE with nothing pending.
  always_comb begin
    fb_addr  = 13'd0;
    fb_wdata = 8'd0;
    fb_we    = 1'b0;
    if (state == IDLE) begin
      if (pend) begin
        fb_addr = pend_tag;
      end else if (host_ram) begin
        fb_addr = host_addr;
        if (host_we) begin
          fb_we    = 1'b1;
          fb_wdata = host_wdata;
        end
      end
    end
  end

  // Host handshake decoded from the registered state: one ack cycle per access.
  always_comb begin
    host_ack   = (state == HOST_WR);
    host_rdata = 8'd0;
`ifdef FB_HOST_READ_EN
    if (state == HOST_RD_CAP) begin
      host_ack   = 1'b1;
      host_rdata = fb_rdata;
    end
`endif
  end

  // Pixel 0 of a group lives in bits [7:6], pixel 3 in bits [1:0].
  always_comb begin
    shade = 2'b00;
    case (pos_q[1:0])
      2'd0: shade = cur_byte[7:6];
      2'd1: shade = cur_byte[5:4];
      2'd2: shade = cur_byte[3:2];
      default: shade = cur_byte[1:0];
    endcase
    pix = pos_in_area ? shade : 2'b00;
  end

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// tb/tb_lcd_fb_arbiter.sv - directed self-checking bench for lcd_fb_arbiter
module tb_lcd_fb_arbiter;

  logic        clk_8m = 1'b0;
  logic        rst;
  logic [7:0]  cur_xpos, cur_ypos;
  logic [1:0]  pix;
  logic        host_req, host_we;
  logic [12:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [12:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic [7:0]  fb_rdata;
  logic        underrun;

  logic [7:0]  mem [0:5759];
  logic        mem_init;
  int          vectors = 0;
  int          miscompares = 0;

  lcd_fb_arbiter dut (
    .clk_8m(clk_8m), .rst(rst), .cur_xpos(cur_xpos), .cur_ypos(cur_ypos), .pix(pix),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_we(fb_we), .fb_rdata(fb_rdata), .underrun(underrun)
  );

  always #5 clk_8m = ~clk_8m;

  // Single-port synchronous framebuffer RAM model, read data one cycle after address.
  always @(posedge clk_8m) begin
    if (mem_init) begin
      for (int i = 0; i < 5760; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h1B;
      mem[5] <= 8'hA5;
    end else if (fb_we && fb_addr < 13'd5760) begin
      mem[fb_addr] <= fb_wdata;
    end
    fb_rdata <= (fb_addr < 13'd5760) ? mem[fb_addr] : 8'h00;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] x, input logic [7:0] y);
    cur_xpos = x;
    cur_ypos = y;
    @(posedge clk_8m);
    #1;
  endtask

  task automatic tick();
    @(posedge clk_8m);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    cur_xpos = 8'd0; cur_ypos = 8'd0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 13'd0; host_wdata = 8'd0;
    tick(); tick();
    chk("rst_pix", pix, 2'd0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ack", host_ack, 1'b0);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_fb_addr", fb_addr, 13'd0);
    rst = 1'b0; mem_init = 1'b0;
    step(8'd0, 8'd0); step(8'd0, 8'd0); step(8'd0, 8'd0);

    // Group 0 re-presented via (159,143): shades 0,1,2,3 from 0x1B.
    step(8'd159, 8'd143);
    step(8'd0, 8'd0); chk("r0_pix_x0", pix, 2'd0); chk("r0_underrun", underrun, 1'b0);
    step(8'd1, 8'd0); chk("r0_pix_x1", pix, 2'd1);
    step(8'd2, 8'd0); chk("r0_pix_x2", pix, 2'd2);
    step(8'd3, 8'd0); chk("r0_pix_x3", pix, 2'd3);

    // Host write 0xE4 to group 40 (row 1, first group), then scan into row 1.
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd40; host_wdata = 8'hE4;
    #1;
    chk("wr_fb_we", fb_we, 1'b1);
    chk("wr_fb_addr", fb_addr, 13'd40);
    tick(); chk("wr_ack", host_ack, 1'b1);
    host_req = 1'b0; host_we = 1'b0;
    tick(); chk("wr_ack_drop", host_ack, 1'b0);
    chk("wr_ram", mem[40], 8'hE4);
    for (int x = 4; x < 160; x++) step(x[7:0], 8'd0);
    chk("row0_underrun", underrun, 1'b0);
    step(8'd0, 8'd1); chk("r1_pix_x0", pix, 2'd3);
    step(8'd1, 8'd1); chk("r1_pix_x1", pix, 2'd2);
    step(8'd2, 8'd1); chk("r1_pix_x2", pix, 2'd1);
    step(8'd3, 8'd1); chk("r1_pix_x3", pix, 2'd0);

    // Host request raised while a boundary fetch is pending: scan goes first.
    step(8'd4, 8'd1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd100; host_wdata = 8'h55;
    #1;
    chk("pri_scan_addr", fb_addr, 13'd42);
    chk("pri_scan_we", fb_we, 1'b0);
    tick(); chk("pri_cap_ack", host_ack, 1'b0); chk("pri_cap_we", fb_we, 1'b0);
    tick(); chk("pri_host_we", fb_we, 1'b1); chk("pri_host_addr", fb_addr, 13'd100);
    chk("pri_host_ack0", host_ack, 1'b0);
    tick(); chk("pri_ack", host_ack, 1'b1);
    host_req = 1'b0; host_we = 1'b0;
    tick(); chk("pri_ack_single", host_ack, 1'b0);

    // Two boundaries one cycle apart: second misses and underrun sticks.
    for (int x = 5; x < 160; x++) step(x[7:0], 8'd1);
    step(8'd0, 8'd2); chk("ur_first_ok", underrun, 1'b0);
    step(8'd4, 8'd2); chk("ur_set", underrun, 1'b1); chk("ur_pix", pix, 2'd0);
    step(8'd5, 8'd2); step(8'd6, 8'd2); step(8'd7, 8'd2); step(8'd8, 8'd2);
    step(8'd8, 8'd2); step(8'd8, 8'd2); step(8'd8, 8'd2);
    chk("ur_sticky", underrun, 1'b1);

    // Out-of-range write: ack next cycle, RAM untouched.
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd6000; host_wdata = 8'h77;
    #1;
    chk("oob_fb_we0", fb_we, 1'b0);
    tick(); chk("oob_ack", host_ack, 1'b1); chk("oob_fb_we1", fb_we, 1'b0);
    host_req = 1'b0; host_we = 1'b0;
    tick(); chk("oob_ack_drop", host_ack, 1'b0); chk("oob_fb_we2", fb_we, 1'b0);

    // Host read of address 5 (0xA5).
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd5;
    #1;
    chk("rd_fb_we", fb_we, 1'b0);
`ifdef FB_HOST_READ_EN
    chk("rd_fb_addr", fb_addr, 13'd5);
    tick(); chk("rd_ack", host_ack, 1'b1); chk("rd_data", host_rdata, 8'hA5);
`else
    chk("rd_fb_addr", fb_addr, 13'd0);
    tick(); chk("rd_ack", host_ack, 1'b1); chk("rd_data", host_rdata, 8'h00);
`endif
    host_req = 1'b0;
    tick(); chk("rd_ack_drop", host_ack, 1'b0); chk("rd_data_drop", host_rdata, 8'h00);

    // Last group boundary wraps the prefetch to group 0; out-of-area shows 0.
    step(8'd156, 8'd143);
    chk("wrap_fb_addr", fb_addr, 13'd0);
    chk("wrap_fb_we", fb_we, 1'b0);
    step(8'd200, 8'd143); chk("oa_pix", pix, 2'd0);
    step(8'd200, 8'd143);
    step(8'd0, 8'd0); chk("wrap_pix_x0", pix, 2'd0);
    step(8'd1, 8'd0); chk("wrap_pix_x1", pix, 2'd1);
    step(8'd3, 8'd0); chk("wrap_pix_x3", pix, 2'd3);
    step(8'd3, 8'd0);

    // Reset during an issuing write: no ack, no RAM update, state cleared.
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd7; host_wdata = 8'h99;
    #1;
    chk("abort_pre_we", fb_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_fb_we", fb_we, 1'b0);
    chk("abort_underrun", underrun, 1'b0);
    chk("abort_pix", pix, 2'd0);
    tick(); chk("abort_ack", host_ack, 1'b0); chk("abort_ram", mem[7], 8'h00);
    host_req = 1'b0; host_we = 1'b0;
    rst = 1'b0;
    tick(); chk("abort_ack2", host_ack, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
